// File: rtl/arith_pkg.sv
// Shared types for the arithmetic issue scheduler: operand and reservation-entry
// records, plus the CDB wakeup helper used at dispatch and in the entries.
package arith_pkg;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [31:0]      val;
    } operand_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [TAG_W-1:0] rd_tag;
        operand_t         rs1;
        operand_t         rs2;
    } rs_entry_t;

    // A waiting operand whose producer tag is on the CDB captures the broadcast value.
    function automatic operand_t wake(operand_t op, logic cdb_valid,
                                      logic [TAG_W-1:0] cdb_tag, logic [31:0] cdb_val);
        wake = op;
        if (!op.rdy && cdb_valid && op.tag == cdb_tag) begin
            wake.rdy = 1'b1;
            wake.val = cdb_val;
        end
    endfunction

endpackage

// File: rtl/arith_issue_sched_if.sv
// Dispatch, CDB, flush and issue signals of the arithmetic issue scheduler.
// master = rename/dispatch + CDB + arith unit side, slave = the scheduler.
interface arith_issue_sched_if #(parameter int DEPTH = 4, parameter int TAG_W = 4);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             flush_i;
    logic             disp_valid_i, disp_ready_o;
    logic [31:0]      disp_pc_i, disp_inst_i;
    logic [TAG_W-1:0] disp_rd_tag_i;
    logic             disp_rs1_rdy_i, disp_rs2_rdy_i;
    logic [TAG_W-1:0] disp_rs1_tag_i, disp_rs2_tag_i;
    logic [31:0]      disp_rs1_val_i, disp_rs2_val_i;
    logic             cdb_valid_i;
    logic [TAG_W-1:0] cdb_tag_i;
    logic [31:0]      cdb_value_i;
    logic             issue_valid_o, issue_ready_i;
    logic [31:0]      issue_pc_o, issue_inst_o, issue_rs1_val_o, issue_rs2_val_o;
    logic [TAG_W-1:0] issue_rd_tag_o;
    logic [CNT_W-1:0] count_o;

    modport master (
        output flush_i, disp_valid_i, disp_pc_i, disp_inst_i, disp_rd_tag_i,
               disp_rs1_rdy_i, disp_rs2_rdy_i, disp_rs1_tag_i, disp_rs2_tag_i,
               disp_rs1_val_i, disp_rs2_val_i, cdb_valid_i, cdb_tag_i, cdb_value_i,
               issue_ready_i,
        input  disp_ready_o, issue_valid_o, issue_pc_o, issue_inst_o,
               issue_rs1_val_o, issue_rs2_val_o, issue_rd_tag_o, count_o
    );

    modport slave (
        input  flush_i, disp_valid_i, disp_pc_i, disp_inst_i, disp_rd_tag_i,
               disp_rs1_rdy_i, disp_rs2_rdy_i, disp_rs1_tag_i, disp_rs2_tag_i,
               disp_rs1_val_i, disp_rs2_val_i, cdb_valid_i, cdb_tag_i, cdb_value_i,
               issue_ready_i,
        output disp_ready_o, issue_valid_o, issue_pc_o, issue_inst_o,
               issue_rs1_val_o, issue_rs2_val_o, issue_rd_tag_o, count_o
    );
endinterface

// File: rtl/arith_age_matrix.sv
// Allocation-order tracker: older[i][j] means entry i was allocated before entry j.
// Grants the single oldest requester; index position plays no part in priority.
module arith_age_matrix #(parameter int DEPTH = 4) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] alloc_oh_i,
    input  logic [DEPTH-1:0] free_oh_i,
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] gnt_o
);
    logic [DEPTH-1:0][DEPTH-1:0] older;

    // A new entry is younger than every entry still resident after this edge.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            older <= '0;
        end else if (flush_i) begin
            older <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (i == j || free_oh_i[i] || free_oh_i[j])
                        older[i][j] <= 1'b0;
                    else if (alloc_oh_i[j])
                        older[i][j] <= valid_i[i];
                    else if (alloc_oh_i[i])
                        older[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            gnt_o[i] = req_i[i];
            for (int j = 0; j < DEPTH; j++)
                if (req_i[j] && older[j][i]) gnt_o[i] = 1'b0;
        end
    end
endmodule

// File: rtl/arith_issue_sched.sv
// Reservation station for the single arithmetic unit: dispatch into free slots,
// CDB wakeup, oldest-ready select into a one-deep registered issue stage.
module arith_issue_sched import arith_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int TAG_W = arith_pkg::TAG_W
) (
    input logic               clk_i,
    input logic               reset_i,
    arith_issue_sched_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rs_entry_t        ent [DEPTH];
    rs_entry_t        disp_ent, sel_ent, out_ent;
    logic [DEPTH-1:0] vld, rdy_vec, alloc_oh, free_oh, gnt;
    logic [TAG_W-1:0] cdb_tag;
    logic [CNT_W-1:0] cnt;
    logic             disp_fire, load, out_vld;

    assign cdb_tag   = bus.cdb_tag_i;
    assign disp_fire = bus.disp_valid_i && bus.disp_ready_o && !bus.flush_i;
    // Lowest clear bit of vld picks the lowest-index free slot.
    assign alloc_oh  = disp_fire ? (~vld & (vld + DEPTH'(1))) : '0;
    assign load      = !out_vld || bus.issue_ready_i;
    assign free_oh   = load ? gnt : '0;

    always_comb begin
        disp_ent.pc      = bus.disp_pc_i;
        disp_ent.inst    = bus.disp_inst_i;
        disp_ent.rd_tag  = bus.disp_rd_tag_i;
        disp_ent.rs1     = wake('{rdy: bus.disp_rs1_rdy_i, tag: bus.disp_rs1_tag_i,
                                  val: bus.disp_rs1_val_i}, bus.cdb_valid_i, cdb_tag, bus.cdb_value_i);
        disp_ent.rs2     = wake('{rdy: bus.disp_rs2_rdy_i, tag: bus.disp_rs2_tag_i,
                                  val: bus.disp_rs2_val_i}, bus.cdb_valid_i, cdb_tag, bus.cdb_value_i);
    end

    always_comb begin
        cnt     = '0;
        sel_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = vld[i] && ent[i].rs1.rdy && ent[i].rs2.rdy;
            cnt        = cnt + CNT_W'(vld[i]);
            if (gnt[i]) sel_ent = ent[i];
        end
    end

    arith_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .flush_i    (bus.flush_i),
        .valid_i    (vld),
        .alloc_oh_i (alloc_oh),
        .free_oh_i  (free_oh),
        .req_i      (rdy_vec),
        .gnt_o      (gnt)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)         vld <= '0;
        else if (bus.flush_i) vld <= '0;
        else                  vld <= (vld & ~free_oh) | alloc_oh;
    end

    // Payload needs no reset: it is only observed through vld.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_oh[i]) begin
                ent[i] <= disp_ent;
            end else begin
                ent[i].rs1 <= wake(ent[i].rs1, bus.cdb_valid_i, cdb_tag, bus.cdb_value_i);
                ent[i].rs2 <= wake(ent[i].rs2, bus.cdb_valid_i, cdb_tag, bus.cdb_value_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            out_vld <= 1'b0;
            out_ent <= '0;
        end else if (bus.flush_i) begin
            out_vld <= 1'b0;
        end else if (load) begin
            out_vld <= |gnt;
            if (|gnt) out_ent <= sel_ent;
        end
    end

    assign bus.disp_ready_o    = (cnt < CNT_W'(DEPTH));
    assign bus.count_o         = cnt;
    assign bus.issue_valid_o   = out_vld;
    assign bus.issue_pc_o      = out_ent.pc;
    assign bus.issue_inst_o    = out_ent.inst;
    assign bus.issue_rd_tag_o  = out_ent.rd_tag;
    assign bus.issue_rs1_val_o = out_ent.rs1.val;
    assign bus.issue_rs2_val_o = out_ent.rs2.val;
endmodule

// File: tb/tb_arith_issue_sched.sv
// Directed bench for arith_issue_sched: an in-order queue model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_arith_issue_sched;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk_i = ~clk_i;

    arith_issue_sched_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus();
    arith_issue_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue in dispatch order, so the first ready element is the oldest ready.
    typedef struct {
        logic [31:0] pc, inst;
        logic [3:0]  rd;
        logic        r1, r2;
        logic [3:0]  t1, t2;
        logic [31:0] v1, v2;
    } m_ent_t;

    m_ent_t q[$];
    m_ent_t m_out;
    m_ent_t e;
    logic   m_ov;
    int     idx;
    bit     full;

    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            q.delete();
            m_ov  = 1'b0;
            m_out = '{default: 0};
        end else if (bus.flush_i) begin
            q.delete();
            m_ov = 1'b0;
        end else begin
            full = (q.size() >= DEPTH);
            if (!m_ov || bus.issue_ready_i) begin
                idx = -1;
                foreach (q[k]) if (idx < 0 && q[k].r1 && q[k].r2) idx = k;
                if (idx >= 0) begin
                    m_out = q[idx];
                    q.delete(idx);
                    m_ov = 1'b1;
                end else begin
                    m_ov = 1'b0;
                end
            end
            if (bus.cdb_valid_i) begin
                foreach (q[k]) begin
                    if (!q[k].r1 && q[k].t1 == bus.cdb_tag_i) begin q[k].r1 = 1'b1; q[k].v1 = bus.cdb_value_i; end
                    if (!q[k].r2 && q[k].t2 == bus.cdb_tag_i) begin q[k].r2 = 1'b1; q[k].v2 = bus.cdb_value_i; end
                end
            end
            if (bus.disp_valid_i && !full) begin
                e.pc = bus.disp_pc_i; e.inst = bus.disp_inst_i; e.rd = bus.disp_rd_tag_i;
                e.t1 = bus.disp_rs1_tag_i; e.t2 = bus.disp_rs2_tag_i;
                e.r1 = bus.disp_rs1_rdy_i; e.v1 = bus.disp_rs1_val_i;
                e.r2 = bus.disp_rs2_rdy_i; e.v2 = bus.disp_rs2_val_i;
                if (!e.r1 && bus.cdb_valid_i && e.t1 == bus.cdb_tag_i) begin e.r1 = 1'b1; e.v1 = bus.cdb_value_i; end
                if (!e.r2 && bus.cdb_valid_i && e.t2 == bus.cdb_tag_i) begin e.r2 = 1'b1; e.v2 = bus.cdb_value_i; end
                q.push_back(e);
            end
        end
    end

    always @(negedge clk_i) begin
        chk("issue_valid", 32'(bus.issue_valid_o), 32'(m_ov));
        chk("count", 32'(bus.count_o), 32'(q.size()));
        chk("disp_ready", 32'(bus.disp_ready_o), 32'(q.size() < DEPTH));
        if (m_ov) begin
            chk("issue_pc", bus.issue_pc_o, m_out.pc);
            chk("issue_inst", bus.issue_inst_o, m_out.inst);
            chk("issue_rd", 32'(bus.issue_rd_tag_o), 32'(m_out.rd));
            chk("issue_rs1", bus.issue_rs1_val_o, m_out.v1);
            chk("issue_rs2", bus.issue_rs2_val_o, m_out.v2);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        bus.disp_valid_i = 1'b0;
        bus.cdb_valid_i  = 1'b0;
        bus.flush_i      = 1'b0;
    endtask

    task automatic disp(input logic [31:0] pc,
                        input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [3:0] t2, input logic [31:0] v2);
        bus.disp_valid_i   = 1'b1;
        bus.disp_pc_i      = pc;
        bus.disp_inst_i    = ~pc;
        bus.disp_rd_tag_i  = pc[5:2];
        bus.disp_rs1_rdy_i = r1; bus.disp_rs1_tag_i = t1; bus.disp_rs1_val_i = v1;
        bus.disp_rs2_rdy_i = r2; bus.disp_rs2_tag_i = t2; bus.disp_rs2_val_i = v2;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        bus.cdb_valid_i = 1'b1;
        bus.cdb_tag_i   = tag;
        bus.cdb_value_i = val;
    endtask

    initial begin
        idle();
        bus.issue_ready_i = 1'b1;
        disp(32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        bus.disp_valid_i = 1'b0;
        cdb(4'h0, 32'h0);
        bus.cdb_valid_i = 1'b0;
        #1 reset_i = 1'b0;
        #1;
        chk("rst_issue_valid", 32'(bus.issue_valid_o), 32'h0);
        chk("rst_issue_pc", bus.issue_pc_o, 32'h0);
        chk("rst_issue_rs1", bus.issue_rs1_val_o, 32'h0);
        chk("rst_count", 32'(bus.count_o), 32'h0);
        #10 reset_i = 1'b1;
        chk("rst_disp_ready", 32'(bus.disp_ready_o), 32'h1);

        // Single ready dispatch: valid two edges later, count 1 then 0
        disp(32'h100, 1'b1, 4'h0, 32'd5, 1'b1, 4'h0, 32'd7);
        step(); idle();
        chk("t1_count1", 32'(bus.count_o), 32'd1);
        chk("t1_not_yet", 32'(bus.issue_valid_o), 32'd0);
        step();
        chk("t1_valid", 32'(bus.issue_valid_o), 32'd1);
        chk("t1_rs1", bus.issue_rs1_val_o, 32'd5);
        chk("t1_rs2", bus.issue_rs2_val_o, 32'd7);
        chk("t1_count0", 32'(bus.count_o), 32'd0);
        step();

        // A waits on tag 3, younger B is ready and goes first
        disp(32'h200, 1'b1, 4'h0, 32'd1, 1'b0, 4'h3, 32'h0);
        step();
        disp(32'h300, 1'b1, 4'h0, 32'd2, 1'b1, 4'h0, 32'd3);
        step(); idle();
        step();
        chk("t2_b_first", bus.issue_pc_o, 32'h300);
        cdb(4'h3, 32'h10);
        step(); idle();
        chk("t2_gap", 32'(bus.issue_valid_o), 32'd0);
        step();
        chk("t2_a_pc", bus.issue_pc_o, 32'h200);
        chk("t2_a_rs2", bus.issue_rs2_val_o, 32'h10);
        step();

        // Two entries woken by one broadcast: older first
        disp(32'h400, 1'b0, 4'h5, 32'h0, 1'b1, 4'h0, 32'd4);
        step();
        disp(32'h500, 1'b0, 4'h5, 32'h0, 1'b1, 4'h0, 32'd6);
        step(); idle();
        cdb(4'h5, 32'h55);
        step(); idle();
        step();
        chk("t3_older", bus.issue_pc_o, 32'h400);
        chk("t3_older_rs1", bus.issue_rs1_val_o, 32'h55);
        step();
        chk("t3_younger", bus.issue_pc_o, 32'h500);
        chk("t3_younger_rs1", bus.issue_rs1_val_o, 32'h55);
        step();

        // Fill while stalled; full blocks dispatch even on the freeing edge
        bus.issue_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            disp(32'h600 + 32'(k * 4), 1'b1, 4'h0, 32'(k), 1'b1, 4'h0, 32'(k + 10));
            step();
        end
        disp(32'h700, 1'b1, 4'h0, 32'd9, 1'b1, 4'h0, 32'd9);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t4_full_count", 32'(bus.count_o), 32'd4);
            chk("t4_full_ready", 32'(bus.disp_ready_o), 32'd0);
            chk("t4_stall_pc", bus.issue_pc_o, 32'h600);
        end
        bus.issue_ready_i = 1'b1;
        step(); idle();
        chk("t4_after_count", 32'(bus.count_o), 32'd3);
        chk("t4_after_ready", 32'(bus.disp_ready_o), 32'd1);
        chk("t4_next_pc", bus.issue_pc_o, 32'h604);
        for (int k = 0; k < 5; k++) step();

        // Dispatch bypass from a same-cycle broadcast
        disp(32'h800, 1'b0, 4'h9, 32'h0, 1'b1, 4'h0, 32'd2);
        cdb(4'h9, 32'hABCD);
        step(); idle();
        chk("t5_count", 32'(bus.count_o), 32'd1);
        step();
        chk("t5_valid", 32'(bus.issue_valid_o), 32'd1);
        chk("t5_rs1", bus.issue_rs1_val_o, 32'hABCD);
        step();

        // Flush with three entries and a held output; concurrent dispatch dropped
        bus.issue_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(32'h900 + 32'(k * 4), 1'b1, 4'h0, 32'(k), 1'b1, 4'h0, 32'(k));
            step();
        end
        idle();
        chk("t6_pre_count", 32'(bus.count_o), 32'd3);
        chk("t6_pre_valid", 32'(bus.issue_valid_o), 32'd1);
        disp(32'h9F0, 1'b1, 4'h0, 32'd1, 1'b1, 4'h0, 32'd1);
        bus.flush_i = 1'b1;
        step(); idle();
        chk("t6_valid", 32'(bus.issue_valid_o), 32'd0);
        chk("t6_count", 32'(bus.count_o), 32'd0);
        step();
        chk("t6_dropped", 32'(bus.count_o), 32'd0);
        bus.issue_ready_i = 1'b1;

        // Asynchronous reset mid-operation
        disp(32'hA00, 1'b1, 4'h0, 32'd1, 1'b1, 4'h0, 32'd1);
        step();
        disp(32'hA04, 1'b0, 4'h7, 32'd0, 1'b1, 4'h0, 32'd1);
        step(); idle();
        #1 reset_i = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count_o), 32'd0);
        chk("arst_valid", 32'(bus.issue_valid_o), 32'd0);
        chk("arst_pc", bus.issue_pc_o, 32'd0);
        chk("arst_ready", 32'(bus.disp_ready_o), 32'd1);
        #1 reset_i = 1'b1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
